// File: rtl/dac_pkg.sv
// Shared types and helpers for the DAC update scheduler: code width, channel
// and FSM state enums, and the saturating add used for ramp and channel values.
package dac_pkg;

  localparam int DW = 10;

  typedef enum logic [1:0] {CH_0A, CH_0B, CH_1A, CH_1B} ch_e;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_e;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? {DW{1'b1}} : s[DW-1:0];
  endfunction

endpackage

// File: rtl/dac_ramp.sv
// Ramp sequencer: offset r steps by a latched increment on each tick for a latched
// number of ticks, then holds. Registered outputs; evt flags any cycle that changes ramp state.
module dac_ramp
  import dac_pkg::*;
#(
  parameter int RAMP_LW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DW-1:0]      ramp_inc,
  input  logic [RAMP_LW-1:0] ramp_len,
  input  logic               ramp_start,
  input  logic               ramp_clr,
  input  logic               tick,
  output logic [DW-1:0]      r,
  output logic               active,
  output logic               evt
);

  logic [RAMP_LW-1:0] rcnt;
  logic [DW-1:0]      inc;

  // clr beats start beats tick when they coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r      <= '0;
      rcnt   <= '0;
      inc    <= '0;
      active <= 1'b0;
    end else if (ramp_clr) begin
      r      <= '0;
      active <= 1'b0;
    end else if (ramp_start) begin
      r      <= '0;
      rcnt   <= ramp_len;
      inc    <= ramp_inc;
      active <= (ramp_len != '0);
    end else if (tick && active) begin
      r    <= sat_add(r, inc);
      rcnt <= rcnt - 1'b1;
      if (rcnt == RAMP_LW'(1)) active <= 1'b0;
    end
  end

  assign evt = ramp_clr | ramp_start | (tick & active);

endmodule

// File: rtl/dac_sched.sv
// DAC update scheduler: shadows + ramp merged into one pending request, sent as a held snapshot
// over vld/rdy (vld 2 clk after an idle event; waits in WAIT for dac rdy). Optional DAC_SCHED_REFRESH_EN.
module dac_sched
  import dac_pkg::*;
#(
  parameter int RAMP_LW     = 8,
  parameter int REFRESH_DIV = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_host_we,
  input  logic [1:0]         i_host_ch,
  input  logic [DW-1:0]      i_host_data,
  input  logic [DW-1:0]      i_ramp_inc,
  input  logic [RAMP_LW-1:0] i_ramp_len,
  input  logic               i_ramp_start,
  input  logic               i_ramp_clr,
  input  logic               i_tick,
  output logic [DW-1:0]      o_dac_data_0a,
  output logic [DW-1:0]      o_dac_data_0b,
  output logic [DW-1:0]      o_dac_data_1a,
  output logic [DW-1:0]      o_dac_data_1b,
  output logic               o_dac_vld,
  input  logic               i_dac_rdy,
  output logic               o_ramp_active,
  output logic               o_busy
);

  logic [DW-1:0] base   [4];
  logic [DW-1:0] data_q [4];
  logic [DW-1:0] r;
  logic          ramp_evt;
  logic          ref_evt;
  logic          pend;
  logic          send_entry;
  state_e        state, state_nxt;

  dac_ramp #(.RAMP_LW(RAMP_LW)) u_ramp (
    .clk        (clk),
    .rst_n      (rst_n),
    .ramp_inc   (i_ramp_inc),
    .ramp_len   (i_ramp_len),
    .ramp_start (i_ramp_start),
    .ramp_clr   (i_ramp_clr),
    .tick       (i_tick),
    .r          (r),
    .active     (o_ramp_active),
    .evt        (ramp_evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) base[k] <= '0;
    end else if (i_host_we) begin
      base[i_host_ch] <= i_host_data;
    end
  end

`ifdef DAC_SCHED_REFRESH_EN
  localparam int RW = $clog2(REFRESH_DIV);
  logic [RW-1:0] ref_cnt;

  // Restarting on SEND entry means refresh only fills gaps in real traffic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    ref_cnt <= '0;
    else if (send_entry || ref_evt) ref_cnt <= '0;
    else                           ref_cnt <= ref_cnt + 1'b1;
  end

  assign ref_evt = (ref_cnt == RW'(REFRESH_DIV - 1));
`else
  assign ref_evt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (pend) state_nxt = S_SEND;
      S_SEND: if (i_dac_rdy) state_nxt = S_WAIT;
      S_WAIT: if (i_dac_rdy) state_nxt = pend ? S_SEND : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign send_entry = (state_nxt == S_SEND) && (state != S_SEND);

  // Pending out of reset so the dac is loaded with zeros; a same-cycle event survives SEND entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= 1'b1;
    else        pend <= i_host_we | ramp_evt | ref_evt | (pend & ~send_entry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
    end else if (send_entry) begin
      for (int k = 0; k < 4; k++) data_q[k] <= sat_add(base[k], r);
    end
  end

  assign o_dac_data_0a = data_q[CH_0A];
  assign o_dac_data_0b = data_q[CH_0B];
  assign o_dac_data_1a = data_q[CH_1A];
  assign o_dac_data_1b = data_q[CH_1B];
  assign o_dac_vld     = (state == S_SEND);
  assign o_busy        = (state != S_IDLE) | pend;

endmodule

// File: tb/tb_dac_sched.sv
// Bench for dac_sched: a behavioural model builds expected snapshots into a queue,
// and a dac responder pops and compares them on every accepted transfer.
module tb_dac_sched;

  localparam int DW  = 10;
  localparam int LW  = 8;
  localparam int MAX = 1023;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_host_we = 1'b0;
  logic [1:0]    i_host_ch = '0;
  logic [DW-1:0] i_host_data = '0;
  logic [DW-1:0] i_ramp_inc = '0;
  logic [LW-1:0] i_ramp_len = '0;
  logic          i_ramp_start = 1'b0;
  logic          i_ramp_clr = 1'b0;
  logic          i_tick = 1'b0;
  logic [DW-1:0] o_dac_data_0a, o_dac_data_0b, o_dac_data_1a, o_dac_data_1b;
  logic          o_dac_vld;
  logic          i_dac_rdy = 1'b1;
  logic          o_ramp_active;
  logic          o_busy;

  dac_sched #(.RAMP_LW(LW), .REFRESH_DIV(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_host_we     (i_host_we),
    .i_host_ch     (i_host_ch),
    .i_host_data   (i_host_data),
    .i_ramp_inc    (i_ramp_inc),
    .i_ramp_len    (i_ramp_len),
    .i_ramp_start  (i_ramp_start),
    .i_ramp_clr    (i_ramp_clr),
    .i_tick        (i_tick),
    .o_dac_data_0a (o_dac_data_0a),
    .o_dac_data_0b (o_dac_data_0b),
    .o_dac_data_1a (o_dac_data_1a),
    .o_dac_data_1b (o_dac_data_1b),
    .o_dac_vld     (o_dac_vld),
    .i_dac_rdy     (i_dac_rdy),
    .o_ramp_active (o_ramp_active),
    .o_busy        (o_busy)
  );

  typedef struct packed {
    logic [DW-1:0] a0, b0, a1, b1;
  } snap_t;

  snap_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    n_acc = 0;
  int    last_acc = 0;
  int    prev_acc = 0;
  int    mbase[4] = '{0, 0, 0, 0};
  int    mr = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int sat(input int b, input int r);
    return (b + r > MAX) ? MAX : b + r;
  endfunction

  function automatic snap_t mk_snap();
    snap_t s;
    s.a0 = DW'(sat(mbase[0], mr));
    s.b0 = DW'(sat(mbase[1], mr));
    s.a1 = DW'(sat(mbase[2], mr));
    s.b1 = DW'(sat(mbase[3], mr));
    return s;
  endfunction

  // dac responder: accept, compare, then stay not-ready for 16 clk
  initial forever begin
    snap_t s;
    @(negedge clk);
    if (rst_n && o_dac_vld && i_dac_rdy) begin
      n_acc++;
      prev_acc = last_acc;
      last_acc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_xfer", 1, 0);
      end else begin
        s = sb.pop_front();
        chk("data_0a", int'(o_dac_data_0a), int'(s.a0));
        chk("data_0b", int'(o_dac_data_0b), int'(s.b0));
        chk("data_1a", int'(o_dac_data_1a), int'(s.a1));
        chk("data_1b", int'(o_dac_data_1b), int'(s.b1));
      end
      @(posedge clk);
      #1 i_dac_rdy = 1'b0;
      repeat (16) @(posedge clk);
      #1 i_dac_rdy = 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input int ch, input int d);
    i_host_we   = 1'b1;
    i_host_ch   = 2'(ch);
    i_host_data = DW'(d);
    mbase[ch]   = d;
    step();
    i_host_we   = 1'b0;
  endtask

  task automatic drv_ramp(input bit st, input bit cl, input bit tk, input int inc, input int len);
    i_ramp_start = st;
    i_ramp_clr   = cl;
    i_tick       = tk;
    i_ramp_inc   = DW'(inc);
    i_ramp_len   = LW'(len);
    step();
    i_ramp_start = 1'b0;
    i_ramp_clr   = 1'b0;
    i_tick       = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((sb.size() != 0 || o_busy) && t < 200) begin
      step();
      t++;
    end
    chk(tag, int'(t < 200), 1);
  endtask

  initial begin
    int n0;
    int exp_out[5] = '{1010, 1020, 1023, 1023, 1023};

    // reset state
    #12;
    chk("rst_vld", int'(o_dac_vld), 0);
    chk("rst_data_0a", int'(o_dac_data_0a), 0);
    chk("rst_data_1b", int'(o_dac_data_1b), 0);
    chk("rst_active", int'(o_ramp_active), 0);
    chk("rst_busy", int'(o_busy), 1);
    sb.push_back(mk_snap());
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle("init_idle");
    repeat (40) step();
    chk("init_one_xfer", n_acc, 1);
    chk("idle_busy", int'(o_busy), 0);

    // single host write: vld exactly two cycles after the write cycle
    n0 = n_acc;
    sb.push_back(mk_snap());
    mbase[2] = 'h155;
    sb.pop_back();
    sb.push_back(mk_snap());
    host_wr(2, 'h155);
    chk("wr_pend_busy", int'(o_busy), 1);
    chk("wr_vld_n1", int'(o_dac_vld), 0);
    step();
    chk("wr_vld_n2", int'(o_dac_vld), 1);
    wait_idle("wr_idle");
    chk("wr_one_xfer", n_acc - n0, 1);

    // ramp with saturation on channel 0a
    host_wr(0, 1000);
    sb.push_back(mk_snap());
    wait_idle("base_idle");
    mr = 0;
    drv_ramp(1, 0, 0, 10, 5);
    sb.push_back(mk_snap());
    chk("ramp_active_start", int'(o_ramp_active), 1);
    wait_idle("start_idle");
    for (int k = 0; k < 5; k++) begin
      mr = (mr + 10 > MAX) ? MAX : mr + 10;
      chk("ramp_model_0a", sat(mbase[0], mr), exp_out[k]);
      drv_ramp(0, 0, 1, 0, 0);
      sb.push_back(mk_snap());
      chk("ramp_active_tick", int'(o_ramp_active), (k < 4) ? 1 : 0);
      repeat (39) step();
      chk("ramp_tick_drained", sb.size(), 0);
    end
    n0 = n_acc;
    drv_ramp(0, 0, 1, 0, 0);
    repeat (40) step();
    chk("tick_inactive_noxfer", n_acc - n0, 0);

    // coalescing: three writes during WAIT collapse into one follow-up
    host_wr(3, 7);
    sb.push_back(mk_snap());
    n0 = n_acc;
    for (int t = 0; t < 50 && n_acc == n0; t++) step();
    chk("coal_first_accept", n_acc - n0, 1);
    host_wr(0, 1);
    host_wr(0, 2);
    host_wr(0, 3);
    sb.push_back(mk_snap());
    wait_idle("coal_idle");
    chk("coal_xfers", n_acc - n0, 2);
    chk("coal_spacing", last_acc - prev_acc, 18);

    // simultaneous ramp controls and zero-length start
    mr = 0;
    drv_ramp(1, 0, 0, 5, 3);
    sb.push_back(mk_snap());
    wait_idle("sim_start_idle");
    mr = 5;
    drv_ramp(0, 0, 1, 0, 0);
    sb.push_back(mk_snap());
    wait_idle("sim_tick_idle");
    n0 = n_acc;
    mr = 0;
    drv_ramp(1, 1, 1, 9, 4);
    sb.push_back(mk_snap());
    chk("sim_active", int'(o_ramp_active), 0);
    wait_idle("sim_idle");
    chk("sim_one_xfer", n_acc - n0, 1);
    n0 = n_acc;
    drv_ramp(1, 0, 0, 9, 0);
    sb.push_back(mk_snap());
    chk("len0_active", int'(o_ramp_active), 0);
    wait_idle("len0_idle");
    chk("len0_xfer", n_acc - n0, 1);

    // idle bus: refresh only when enabled
    n0 = n_acc;
`ifdef DAC_SCHED_REFRESH_EN
    sb.push_back(mk_snap());
    for (int t = 0; t < 200 && n_acc == n0; t++) step();
    chk("refresh_xfer", n_acc - n0, 1);
`else
    repeat (200) step();
    chk("no_refresh", n_acc - n0, 0);
`endif
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_sched.md
# dac_sched

Update scheduler and ramp sequencer for the 4-channel serial DAC shifter (`dac`).
- Holds a 10-bit base level per channel (0a, 0b, 1a, 1b), written by the host.
- Adds a common time-varying ramp offset driven by the sample tick, saturating at full scale.
- Merges host writes, ramp steps and (optionally) periodic refresh into a single pending request.
- Issues coalesced snapshots to `dac` over its vld/rdy handshake. Sits between the register file / acquisition timing and `dac`.

## Interface
- DW, 10, DAC code width
- RAMP_LW, 8, width of ramp length counter
- REFRESH_DIV, 1024, clk cycles between forced refreshes (only with DAC_SCHED_REFRESH_EN)

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- i_host_we  in  1  base-level write strobe
- i_host_ch  in  2  channel select: 0=0a, 1=0b, 2=1a, 3=1b
- i_host_data  in  DW  base level
- i_ramp_inc  in  DW  ramp increment per tick, sampled at start
- i_ramp_len  in  RAMP_LW  number of ticks in ramp, sampled at start
- i_ramp_start  in  1  start/restart ramp
- i_ramp_clr  in  1  force ramp offset to 0 and stop
- i_tick  in  1  ramp step strobe
- o_dac_data_0a/0b/1a/1b  out  DW  snapshot to dac
- o_dac_vld  out  1  snapshot valid
- i_dac_rdy  in  1  dac ready
- o_ramp_active  out  1  ramp running
- o_busy  out  1  FSM not IDLE or request pending

## Operation
- **Shadow registers.** base[4] are DW bits each; reset value 0. A write updates `base[i_host_ch]` and sets `pend`.
- **Ramp.**
  - `r` (DW bits, reset 0), `rcnt` (RAMP_LW), `inc` latched.
  - `i_ramp_start`: r←0, rcnt←i_ramp_len, inc←i_ramp_inc, active←(i_ramp_len≠0), set pend.
  - Tick while active: r←min(r+inc, 2^DW−1); rcnt−1; active clears when rcnt reaches 0; set pend. After the ramp ends, r holds its final value.
  - Tick while inactive: no effect.
  - `i_ramp_clr`: r←0, active←0, set pend.
  - Priority: clr > start > tick in the same cycle.
- **Channel value.** out_ch = min(base_ch + r, 2^DW−1). The sum is computed DW+1 bits wide, then saturated.
- **pend behaviour.**
  - `pend` is set to 1 out of reset, so the DAC is initialised to zeros.
  - `pend` is cleared when SEND is entered.
  - Any event in the same cycle as SEND entry keeps `pend` set.
- **FSM (IDLE, SEND, WAIT), reset state IDLE.**
  - IDLE: pend → SEND.
  - SEND: o_dac_vld=1; data registered from out_ch on entry and held stable. On vld&rdy → WAIT.
  - WAIT: o_dac_vld=0. When i_dac_rdy=1: pend → SEND, else → IDLE.
- **Coalescing.** Multiple events during SEND/WAIT collapse into one follow-up transfer carrying the latest values. No event is lost; intermediate values may be skipped.
- **Reset mid-transfer.** Everything clears at once. o_dac_vld drops asynchronously; dac itself restarts via its own reset.

## Timing
- Reset values: o_dac_vld=0, o_dac_data_*=0, o_ramp_active=0, o_busy=1 (pend set).
- Event at cycle N (registered at end of N): pend=1 in N+1, SEND (vld=1) in N+2 if FSM was IDLE.
- Accept at cycle A: dac ready low A+1..A+16, high A+17. WAIT→SEND gives vld again at A+18, so back-to-back accept spacing is 18 clk.
- Data is stable for all cycles of o_dac_vld=1. vld never drops without a handshake, except on reset.

## Configuration
- `DAC_SCHED_REFRESH_EN` defined:
  - A free-running counter sets pend every REFRESH_DIV clk.
  - The counter reloads on every SEND entry, so refresh fires only after REFRESH_DIV idle cycles.
- Undefined: counter absent. Transfers occur only on host write, ramp events and reset.

## Structure
- Package `dac_pkg`:
  - DW default.
  - Channel enum CH_0A..CH_1B.
  - FSM state enum S_IDLE/S_SEND/S_WAIT.
  - Saturating-add function.
- Sub-module `dac_ramp`: holds r, rcnt, inc and active, and outputs r and o_ramp_active.
- The top holds the shadows, pend, FSM and refresh timer.

## Test plan
- **Reset init.** Release reset, rdy=1 → one transfer, all data 0. Next vld 18 clk after accept only if another event occurs.
- **Single host write.** Write ch=2 data=0x155 → vld at N+2 with 1a=0x155, others 0.
- **Ramp with saturation.** base_0a=1000, start inc=10 len=5, five ticks spaced 40 clk:
  - 0a sends 1010, 1020, 1023, 1023, 1023.
  - active drops after the 5th tick.
- **Coalescing.** Three host writes to ch0 (1, 2, 3) during WAIT → exactly one follow-up transfer with 0a=3.
- **Simultaneous events.** start+tick+clr in the same cycle → r=0, active=0, one pend. len=0 start → active stays 0, transfer issued.
- **Refresh (macro on, REFRESH_DIV=64).** Idle bus → transfers every 64 idle clk after the last SEND entry. Macro off → no transfers.
